// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the RF write port between two writeback sources, plus a RAW pending-write scoreboard.
// Accepted write appears on rf_we/waddr/wdata one cycle later; no internal buffering, a loser simply sees ready low.
module rf_write_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb0_valid_i,
    input  logic [AW-1:0]        wb0_addr_i,
    input  logic [XLEN-1:0]      wb0_data_i,
    output logic                 wb0_ready_o,
    input  logic                 wb1_valid_i,
    input  logic [AW-1:0]        wb1_addr_i,
    input  logic [XLEN-1:0]      wb1_data_i,
    output logic                 wb1_ready_o,
    input  logic                 reserve_i,
    input  logic [AW-1:0]        reserve_addr_i,
    input  logic [AW-1:0]        chk_addr1_i,
    input  logic [AW-1:0]        chk_addr2_i,
    output logic                 hazard_o,
    output logic [(1<<AW)-1:0]   pending_o,
    output logic                 rf_we_o,
    output logic [AW-1:0]        rf_waddr_o,
    output logic [XLEN-1:0]      rf_wdata_o
);

    localparam int NREG = 1 << AW;

    // ptr_q = 0 favours req0 on a conflict, 1 favours req1
    logic            ptr_q;
    logic            conflict;
    logic            gnt0;
    logic            gnt1;
    logic            acc;
    logic [AW-1:0]   acc_addr;
    logic [XLEN-1:0] acc_data;
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        conflict = wb0_valid_i & wb1_valid_i;
        if (!rst_i) begin
            if (conflict) begin
                gnt0 = ~ptr_q;
                gnt1 = ptr_q;
            end else begin
                gnt0 = wb0_valid_i;
                gnt1 = wb1_valid_i;
            end
        end
    end

    assign wb0_ready_o = gnt0;
    assign wb1_ready_o = gnt1;
    assign acc         = gnt0 | gnt1;
    assign acc_addr    = gnt1 ? wb1_addr_i : wb0_addr_i;
    assign acc_data    = gnt1 ? wb1_data_i : wb0_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= 1'b0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            // granted side is always ptr_q on a conflict, so flipping hands priority to the loser
            if (conflict) begin
                ptr_q <= ~ptr_q;
            end
            rf_we_o <= acc & (acc_addr != '0);
            if (acc) begin
                rf_waddr_o <= acc_addr;
                rf_wdata_o <= acc_data;
            end
        end
    end

    // Reserve is applied after the clear so a same-edge re-reservation by a newer producer survives
    always_comb begin
        pend_d = pend_q;
        if (rf_we_o) begin
            pend_d[rf_waddr_o] = 1'b0;
        end
        if (reserve_i) begin
            pend_d[reserve_addr_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;
    assign hazard_o  = ((chk_addr1_i != '0) & pend_q[chk_addr1_i]) |
                       ((chk_addr2_i != '0) & pend_q[chk_addr2_i]);

endmodule
